// File: rtl/lcd_write_arbiter.sv
// rtl/lcd_write_arbiter.sv - two-requester arbiter for the LCD byte writer with settle delay and wr_finish timeout
module lcd_write_arbiter #(
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned SHORT_DELAY = 2000,
    parameter int unsigned LONG_DELAY  = 82000,
    parameter int unsigned TIMEOUT     = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_active,
    input  logic       req0,
    input  logic       rs0,
    input  logic [7:0] data0,
    input  logic       req1,
    input  logic       rs1,
    input  logic [7:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic [1:0] grant,
    output logic       wr_enable,
    output logic       wr_rs,
    output logic [7:0] wr_data,
    input  logic       wr_finish,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    localparam logic [CNT_W-1:0] SHORT_CNT   = CNT_W'(SHORT_DELAY);
    localparam logic [CNT_W-1:0] LONG_CNT    = CNT_W'(LONG_DELAY);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_owner_q, last_owner_d;
    logic [1:0]         grant_q, grant_d;
    logic               wr_enable_q, wr_enable_d;
    logic               wr_rs_q, wr_rs_d;
    logic [7:0]         wr_data_q, wr_data_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;
    logic               timeout_err_q, timeout_err_d;
    logic               busy_q, busy_d;

    logic               elig0;
    logic               elig1;
    logic               pick1;
    logic               long_cmd;
    logic [CNT_W-1:0]   cnt_dec;

    assign elig0    = req0;
    assign elig1    = req1 & ~init_active;
    // On a tie the requester that did not own the last transaction wins.
    assign pick1    = elig1 & (~elig0 | ~last_owner_q);
    // Clear display and return home need the long HD44780 settle time.
    assign long_cmd = ~wr_rs_q & ((wr_data_q == 8'h01) | (wr_data_q == 8'h02) | (wr_data_q == 8'h03));
    assign cnt_dec  = (cnt_q == '0) ? '0 : cnt_q - 1'b1;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_owner_d  = last_owner_q;
        grant_d       = grant_q;
        wr_enable_d   = 1'b0;
        wr_rs_d       = wr_rs_q;
        wr_data_d     = wr_data_q;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        timeout_err_d = timeout_err_q;

        case (state_q)
            ST_IDLE: begin
                if (elig0 | elig1) begin
                    grant_d      = pick1 ? 2'b10 : 2'b01;
                    last_owner_d = pick1;
                    wr_rs_d      = pick1 ? rs1 : rs0;
                    wr_data_d    = pick1 ? data1 : data0;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wr_enable_d = 1'b1;
                cnt_d       = TIMEOUT_CNT;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (wr_finish) begin
                    cnt_d   = long_cmd ? LONG_CNT : SHORT_CNT;
                    ack0_d  = grant_q[0];
                    ack1_d  = grant_q[1];
                    state_d = ST_HOLD;
                end else if (cnt_dec == '0) begin
                    // Aborted byte: the controller state is unknown, so only the short settle applies.
                    timeout_err_d = 1'b1;
                    cnt_d         = SHORT_CNT;
                    ack0_d        = grant_q[0];
                    ack1_d        = grant_q[1];
                    state_d       = ST_HOLD;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    grant_d   = 2'b00;
                    wr_rs_d   = 1'b0;
                    wr_data_d = 8'h00;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            last_owner_q  <= 1'b1;
            grant_q       <= 2'b00;
            wr_enable_q   <= 1'b0;
            wr_rs_q       <= 1'b0;
            wr_data_q     <= 8'h00;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_owner_q  <= last_owner_d;
            grant_q       <= grant_d;
            wr_enable_q   <= wr_enable_d;
            wr_rs_q       <= wr_rs_d;
            wr_data_q     <= wr_data_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign grant       = grant_q;
    assign wr_enable   = wr_enable_q;
    assign wr_rs       = wr_rs_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb/tb_lcd_write_arbiter.sv - self-checking bench for lcd_write_arbiter
module tb_lcd_write_arbiter;

    localparam int CW    = 12;
    localparam int SHORT = 20;
    localparam int LONG  = 60;
    localparam int TMO   = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       init_active = 1'b0;
    logic       req0 = 1'b0, rs0 = 1'b0, req1 = 1'b0, rs1 = 1'b0;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic       wr_finish = 1'b0;
    logic       ack0, ack1, wr_enable, wr_rs, busy, timeout_err;
    logic [1:0] grant;
    logic [7:0] wr_data;

    always #5 clk = ~clk;

    lcd_write_arbiter #(
        .CNT_W(CW), .SHORT_DELAY(SHORT), .LONG_DELAY(LONG), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .init_active(init_active),
        .req0(req0), .rs0(rs0), .data0(data0),
        .req1(req1), .rs1(rs1), .data1(data1),
        .ack0(ack0), .ack1(ack1), .grant(grant),
        .wr_enable(wr_enable), .wr_rs(wr_rs), .wr_data(wr_data),
        .wr_finish(wr_finish), .busy(busy), .timeout_err(timeout_err)
    );

    int total = 0, bad = 0, cyc = 0;
    int fin_lat = 0, fin_cnt = 0, force_lat = -1;
    int a0cnt = 0, a1cnt = 0;
    bit sb_en = 0, txn_act = 0, new_txn = 0, m_last = 1, m_terr = 0;
    bit t_owner = 0, t_rs = 0, t_to = 0;
    logic [7:0] t_data = 8'h00;
    int t_en = 0, t_ack = 0, t_end = 0;
    logic p_req0, p_req1, p_init, p_rs0, p_rs1;
    logic [7:0] p_d0, p_d1;
    bit auto_req = 0, pend0 = 0, pend1 = 0;

    typedef struct {
        bit         r0; bit s0; logic [7:0] d0;
        bit         r1; bit s1; logic [7:0] d1;
        bit         init; int lat;
        int         exp_g; int exp_hold; bit exp_terr;
    } vec_t;
    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic bit long_cmd(input bit rs, input logic [7:0] d);
        return !rs && (d >= 8'd1) && (d <= 8'd3);
    endfunction

    function automatic int pick_lat();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 0;
        if (r == 1) return TMO - 1;
        return int'($urandom_range(1, 8));
    endfunction

    function automatic logic [7:0] rnd_byte();
        if ($urandom_range(0, 3) == 0) return 8'($urandom_range(0, 4));
        return 8'($urandom_range(0, 255));
    endfunction

    // Transaction-level reference: grant choice, byte, and the cycle of each handshake event.
    task automatic monitor();
        bit e0, e1;
        int exp_g, d;
        new_txn = 0;
        if (!sb_en) return;
        if (!txn_act) begin
            e0 = p_req0;
            e1 = p_req1 && !p_init;
            if (e0 && e1)  exp_g = m_last ? 1 : 2;
            else if (e0)   exp_g = 1;
            else if (e1)   exp_g = 2;
            else           exp_g = 0;
            chk("idle_grant", 32'(grant), 32'(exp_g));
            chk("idle_busy", 32'(busy), 32'(exp_g != 0));
            chk("idle_pulses", 32'({ack0, ack1, wr_enable}), 32'(0));
            if (exp_g != 0) begin
                txn_act = 1;
                new_txn = 1;
                t_owner = (exp_g == 2);
                m_last  = t_owner;
                t_rs    = t_owner ? p_rs1 : p_rs0;
                t_data  = t_owner ? p_d1 : p_d0;
                fin_lat = (force_lat >= 0) ? force_lat : pick_lat();
                t_to    = (fin_lat == 0) || (fin_lat >= TMO);
                t_en    = cyc + 1;
                t_ack   = t_en + (t_to ? TMO : fin_lat + 1);
                d       = (t_to || !long_cmd(t_rs, t_data)) ? SHORT : LONG;
                t_end   = t_ack + d + 1;
            end else begin
                chk("idle_byte", 32'({wr_rs, wr_data}), 32'(0));
            end
        end else if (cyc == t_end) begin
            chk("end_state", 32'({busy, grant, wr_rs, wr_data, ack0, ack1, wr_enable}), 32'(0));
            txn_act = 0;
        end else begin
            chk("own_grant", 32'(grant), 32'(t_owner ? 2 : 1));
            chk("own_busy", 32'(busy), 32'(1));
            chk("own_byte", 32'({wr_rs, wr_data}), 32'({t_rs, t_data}));
            chk("own_wr_en", 32'(wr_enable), 32'(cyc == t_en));
            chk("own_ack", 32'({ack1, ack0}), 32'((cyc == t_ack) ? (t_owner ? 2 : 1) : 0));
            if (cyc == t_ack && t_to) m_terr = 1;
        end
        chk("terr", 32'(timeout_err), 32'(m_terr));
    endtask

    task automatic drive_random();
        if (ack0) begin
            req0 = 0; pend0 = 0;
        end else if (!req0 && !pend0 && $urandom_range(0, 7) == 0) begin
            req0 = 1; rs0 = 1'($urandom_range(0, 1)); data0 = rnd_byte();
        end else if (req0 && txn_act && !t_owner && $urandom_range(0, 63) == 0) begin
            req0 = 0; pend0 = 1;
        end
        if (ack1) begin
            req1 = 0; pend1 = 0;
        end else if (!req1 && !pend1 && $urandom_range(0, 7) == 0) begin
            req1 = 1; rs1 = 1'($urandom_range(0, 1)); data1 = rnd_byte();
        end else if (req1 && txn_act && t_owner && $urandom_range(0, 63) == 0) begin
            req1 = 0; pend1 = 1;
        end
        if ($urandom_range(0, 39) == 0) init_active = !init_active;
    endtask

    task automatic tick();
        p_req0 = req0; p_req1 = req1; p_init = init_active;
        p_rs0 = rs0; p_rs1 = rs1; p_d0 = data0; p_d1 = data1;
        @(negedge clk);
        cyc++;
        if (ack0) a0cnt++;
        if (ack1) a1cnt++;
        wr_finish = 0;
        if (fin_cnt > 0) begin
            fin_cnt--;
            if (fin_cnt == 0) wr_finish = 1;
        end
        if (wr_enable === 1'b1 && fin_lat > 0) fin_cnt = fin_lat;
        monitor();
        if (auto_req) drive_random();
    endtask

    task automatic wait_new(output int g);
        int n;
        n = 0;
        do begin tick(); n++; end while (!new_txn && n < 400);
        chk("wait_new", 32'(new_txn), 32'(1));
        g = int'(grant);
    endtask

    task automatic wait_ack(input int i);
        int n;
        n = 0;
        do begin tick(); n++; end while (!((i == 1) ? ack1 : ack0) && n < 400);
        chk("wait_ack", 32'((i == 1) ? ack1 : ack0), 32'(1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 400) begin tick(); n++; end
        chk("wait_idle", 32'(busy), 32'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int g, n, a0b, a1b;

        vt[0] = '{1, 0, 8'h38, 0, 0, 8'h00, 0, 5,       1, SHORT + 1, 0};
        vt[1] = '{1, 0, 8'h02, 1, 1, 8'h01, 0, 4,       2, SHORT + 1, 0};
        vt[2] = '{1, 0, 8'h02, 1, 1, 8'h44, 0, 3,       1, LONG + 1,  0};
        vt[3] = '{0, 0, 8'h00, 1, 0, 8'h01, 0, 6,       2, LONG + 1,  0};
        vt[4] = '{1, 0, 8'h03, 1, 1, 8'h45, 1, 2,       1, LONG + 1,  0};
        vt[5] = '{1, 0, 8'h04, 1, 1, 8'h46, 1, 2,       1, SHORT + 1, 0};
        vt[6] = '{0, 0, 8'h00, 1, 0, 8'h01, 0, 0,       2, SHORT + 1, 1};
        vt[7] = '{1, 0, 8'h02, 0, 0, 8'h00, 0, TMO - 1, 1, LONG + 1,  1};
        vt[8] = '{1, 0, 8'h00, 1, 0, 8'h03, 0, 1,       2, LONG + 1,  1};
        vt[9] = '{1, 0, 8'h00, 1, 0, 8'h03, 0, 1,       1, SHORT + 1, 1};

        rst = 0;
        repeat (3) tick();
        chk("reset_outputs", 32'({grant, busy, wr_enable, wr_rs, wr_data, ack0, ack1, timeout_err}), 32'(0));
        rst = 1;
        sb_en = 1;

        // Both requesting from reset: strict alternation starting with requester 0.
        req0 = 1; rs0 = 0; data0 = 8'h38;
        req1 = 1; rs1 = 1; data1 = 8'h41;
        force_lat = 3;
        for (int k = 0; k < 4; k++) begin
            wait_new(g);
            chk("rr_order", 32'(g), 32'((k % 2 == 1) ? 2 : 1));
            wait_ack(k % 2);
            if (k % 2 == 1) req1 = 0; else req0 = 0;
            tick();
            if (k < 3) begin
                if (k % 2 == 1) req1 = 1; else req0 = 1;
            end
        end
        req0 = 0; req1 = 0;
        wait_idle();
        chk("rr_ack0_count", 32'(a0cnt), 32'(2));
        chk("rr_ack1_count", 32'(a1cnt), 32'(2));

        // init_active: requester 1 is held off while requester 0 is served twice.
        init_active = 1; req1 = 1; rs1 = 1; data1 = 8'h55; force_lat = 2;
        a1b = a1cnt;
        for (int k = 0; k < 2; k++) begin
            req0 = 1; rs0 = 1; data0 = 8'(8'h30 + k);
            wait_new(g);
            chk("init_grant", 32'(g), 32'(1));
            wait_ack(0);
            req0 = 0;
            wait_idle();
            repeat (3) tick();
        end
        chk("init_no_ack1", 32'(a1cnt - a1b), 32'(0));
        chk("init_blocked_idle", 32'(busy), 32'(0));
        init_active = 0;
        wait_new(g);
        chk("init_release_grant", 32'(g), 32'(2));
        wait_ack(1);
        req1 = 0;
        wait_idle();

        for (int i = 0; i < 10; i++) begin
            req0 = vt[i].r0; rs0 = vt[i].s0; data0 = vt[i].d0;
            req1 = vt[i].r1; rs1 = vt[i].s1; data1 = vt[i].d1;
            init_active = vt[i].init;
            force_lat = vt[i].lat;
            wait_new(g);
            chk($sformatf("vec%0d_grant", i), 32'(g), 32'(vt[i].exp_g));
            chk($sformatf("vec%0d_byte", i), 32'({wr_rs, wr_data}),
                32'((vt[i].exp_g == 2) ? {vt[i].s1, vt[i].d1} : {vt[i].s0, vt[i].d0}));
            wait_ack((vt[i].exp_g == 2) ? 1 : 0);
            req0 = 0; req1 = 0;
            n = 0;
            while (busy && n < 200) begin n++; tick(); end
            chk($sformatf("vec%0d_hold", i), 32'(n), 32'(vt[i].exp_hold));
            chk($sformatf("vec%0d_terr", i), 32'(timeout_err), 32'(vt[i].exp_terr));
        end
        init_active = 0;

        // Reset while waiting for wr_finish: asynchronous clear, no ack, req0 wins afterwards.
        force_lat = 0;
        req0 = 1; rs0 = 0; data0 = 8'h01;
        wait_new(g);
        repeat (4) tick();
        chk("rst_pre_busy", 32'(busy), 32'(1));
        sb_en = 0;
        req1 = 1; rs1 = 1; data1 = 8'h22;
        #2 rst = 0;
        #1;
        chk("rst_async_out", 32'({grant, busy, wr_enable, wr_rs, wr_data, ack0, ack1, timeout_err}), 32'(0));
        a0b = a0cnt;
        repeat (3) tick();
        chk("rst_no_ack", 32'(a0cnt - a0b), 32'(0));
        chk("rst_held_idle", 32'({busy, grant}), 32'(0));
        rst = 1;
        txn_act = 0; m_last = 1; m_terr = 0; fin_cnt = 0; wr_finish = 0;
        force_lat = 2;
        sb_en = 1;
        wait_new(g);
        chk("rst_first_grant", 32'(g), 32'(1));
        wait_ack(0);
        req0 = 0;

        force_lat = -1;
        pend0 = 0; pend1 = 0;
        auto_req = 1;
        repeat (5000) tick();
        auto_req = 0;
        req0 = 0; req1 = 0;
        wait_idle();
        repeat (3) tick();
        chk("final_idle", 32'({busy, grant}), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
